// File: rtl/and_reduce_scheduler.sv
// and_reduce_scheduler: two-requester round-robin engine that AND-reduces each operand one bit per clock
// and returns the 1-bit result, tagged with its source, on a valid/ready port.
module and_reduce_scheduler #(
  parameter int WIDTH = 4,
  parameter bit EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_src,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < 2) begin : g_width_chk
    $error("and_reduce_scheduler: WIDTH must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;
  state_t           state_q;
  logic             acc_q, src_q, last_q, out_valid_q, out_data_q, out_src_q, busy_q;
  logic [WIDTH-2:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             idle, gnt, take, acc_n;
  logic [WIDTH-1:0] din;
  always_comb begin
    idle  = (state_q == IDLE) & ~rst;
    gnt   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    take  = idle & (req0_valid | req1_valid);
    din   = gnt ? req1_data : req0_data;
    acc_n = acc_q & sh_q[0];
  end
  assign req0_ready = idle & req0_valid & ~gnt;
  assign req1_ready = idle & req1_valid & gnt;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign busy       = busy_q;
  // last_q resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      src_q       <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_src_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          acc_q  <= din[0];
          sh_q   <= din[WIDTH-1:1];
          cnt_q  <= CW'(WIDTH - 1);
          src_q  <= gnt;
          last_q <= gnt;
          busy_q <= 1'b1;
          if (EARLY_EXIT && !din[0]) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= 1'b0;
            out_src_q   <= gnt;
          end else
            state_q <= REDUCE;
        end
        REDUCE: begin
          acc_q <= acc_n;
          sh_q  <= sh_q >> 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1) || (EARLY_EXIT && !acc_n)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_n;
            out_src_q   <= src_q;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
